// File: rtl/uart_tx_arbiter.sv
// Two-requester UART TX arbiter with message-granularity round-robin and idle timeout,
// feeding a built-in 8N1 serializer that drives the shared uart_tx pad.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT   = 104,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       uart_tx,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_pulse
);

  localparam int DATA_W = 8;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  ser_state_t        ser_state;
  arb_state_t        arb_state;
  logic              owner;
  logic              rr_ptr;
  logic [TO_W-1:0]   to_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] tx_byte;

  logic              ser_idle;
  logic              xfer0;
  logic              xfer1;
  logic              xfer;
  logic              xfer_src;
  logic [DATA_W-1:0] xfer_data;
  logic              xfer_last;
  logic              owner_valid;

  assign ser_idle = (ser_state == S_IDLE);
  assign busy     = !ser_idle;

  // Ready is offered only while the serializer is idle; a locked owner is offered
  // ready regardless of its valid, which keeps the other requester fully shut out.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (ser_idle) begin
      if (arb_state == ARB_LOCKED) begin
        req0_ready = !owner;
        req1_ready = owner;
      end else if (req0_valid && req1_valid) begin
        req0_ready = !rr_ptr;
        req1_ready = rr_ptr;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign xfer0       = req0_valid && req0_ready;
  assign xfer1       = req1_valid && req1_ready;
  assign xfer        = xfer0 || xfer1;
  assign xfer_src    = xfer1;
  assign xfer_data   = xfer1 ? req1_data : req0_data;
  assign xfer_last   = xfer1 ? req1_last : req0_last;
  assign owner_valid = owner ? req1_valid : req0_valid;

  // Arbiter: ownership, round-robin pointer and idle timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_state     <= ARB_IDLE;
      owner         <= 1'b0;
      rr_ptr        <= 1'b0;
      grant         <= 2'b00;
      to_cnt        <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (arb_state)
        ARB_IDLE: begin
          to_cnt <= '0;
          if (xfer) begin
            if (xfer_last) begin
              rr_ptr <= !xfer_src;
            end else begin
              arb_state <= ARB_LOCKED;
              owner     <= xfer_src;
              grant     <= xfer_src ? 2'b10 : 2'b01;
            end
          end
        end
        ARB_LOCKED: begin
          if (xfer) begin
            to_cnt <= '0;
            if (xfer_last) begin
              arb_state <= ARB_IDLE;
              grant     <= 2'b00;
              rr_ptr    <= !owner;
            end
          end else if (ser_idle && !owner_valid) begin
            if (to_cnt == TO_LAST) begin
              arb_state     <= ARB_IDLE;
              grant         <= 2'b00;
              rr_ptr        <= !owner;
              to_cnt        <= '0;
              timeout_pulse <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Byte latch: captured only at the transfer edge, no reset needed
  always_ff @(posedge clk) begin
    if (xfer) begin
      tx_byte <= xfer_data;
    end
  end

  // Serializer: START, 8 data bits LSB first, STOP, each CLKS_PER_BIT cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      ser_state <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      uart_tx   <= 1'b1;
    end else begin
      case (ser_state)
        S_IDLE: begin
          if (xfer) begin
            ser_state <= S_START;
            baud_cnt  <= '0;
            uart_tx   <= 1'b0;
          end
        end
        S_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            ser_state <= S_DATA;
            uart_tx   <= tx_byte[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              ser_state <= S_STOP;
              uart_tx   <= 1'b1;
            end else begin
              uart_tx <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt  <= '0;
            ser_state <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: ser_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected frames, a monitor
// decodes uart_tx and the transfer handshakes and compares against the queue.
module tb_uart_tx_arbiter;

  localparam int CPB = 4;
  localparam int TO  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, uart_tx, busy, timeout_pulse;
  logic [1:0] grant;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .uart_tx(uart_tx), .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic src; logic [1:0] gnt; logic [7:0] data; } exp_t;
  typedef struct packed { logic src; logic [1:0] gnt; } xfr_t;

  exp_t exp_q[$];
  xfr_t act_q[$];
  exp_t e;
  xfr_t a;

  int   n_checks = 0;
  int   n_fail = 0;
  bit   rx_active = 0;
  int   rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  int   pulse_cnt = 0, viol_cnt = 0, gap_cnt = 0;
  bit   gap_en = 0, prev_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic src, input logic [1:0] gnt, input logic [7:0] d);
    exp_t r;
    r.src = src; r.gnt = gnt; r.data = d;
    return r;
  endfunction

  function automatic xfr_t mkx(input logic src, input logic [1:0] gnt);
    xfr_t r;
    r.src = src; r.gnt = gnt;
    return r;
  endfunction

  // Monitor: handshakes, uart frame decode, pulses, ready violations, idle gaps
  always @(negedge clk) begin
    if (reset) begin
      if (rx_active) begin
        rx_active = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (act_q.size() > 0) void'(act_q.pop_front());
      end
    end else begin
      if (req0_valid && req0_ready) act_q.push_back(mkx(1'b0, grant));
      if (req1_valid && req1_ready) act_q.push_back(mkx(1'b1, grant));
      if (timeout_pulse) pulse_cnt++;
      if ((grant == 2'b01 && req1_ready) || (grant == 2'b10 && req0_ready)) viol_cnt++;
      if (busy) begin
        if (!prev_busy && gap_en) chk("idle_gap", gap_cnt, 1);
        gap_cnt = 0;
      end else begin
        gap_cnt++;
      end
      prev_busy = busy;

      if (!rx_active) begin
        if (uart_tx === 1'b0) begin
          rx_active = 1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == CPB / 2) begin
          chk("start_bit", uart_tx, 0);
        end else if (rx_cnt >= CPB + CPB / 2 && rx_cnt <= 8 * CPB + CPB / 2 &&
                     (rx_cnt - CPB / 2) % CPB == 0) begin
          rx_byte[(rx_cnt - CPB / 2) / CPB - 1] = uart_tx;
        end else if (rx_cnt == 9 * CPB + CPB / 2) begin
          chk("stop_bit", uart_tx, 1);
          rx_active = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_frame: got 0x%0h, expected no frame", rx_byte);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", rx_byte, e.data);
            if (act_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL frame_handshake: got no transfer, expected src %0d", e.src);
            end else begin
              a = act_q.pop_front();
              chk("frame_src", a.src, e.src);
              chk("frame_grant", a.gnt, e.gnt);
            end
          end
        end
      end
    end
  end

  task automatic set_req(input bit src, input logic v, input logic [7:0] d, input logic l);
    if (src) begin
      req1_valid = v; req1_data = d; req1_last = l;
    end else begin
      req0_valid = v; req0_data = d; req0_last = l;
    end
  endtask

  task automatic wait_xfer(input bit src);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (src ? req1_ready : req0_ready) break;
    end
    chk(src ? "xfer_wait_req1" : "xfer_wait_req0", k < 2000, 1);
  endtask

  // msgs[i] = {last, data}
  task automatic drive(input bit src, input logic [1:0][8:0] msgs, input int n);
    for (int i = 0; i < n; i++) begin
      set_req(src, 1'b1, msgs[i][7:0], msgs[i][8]);
      wait_xfer(src);
      @(posedge clk);
      #1;
    end
    set_req(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !rx_active) break;
    end
    chk("drain", k < 3000, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0;
    logic [1:0] gs, pg;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_pulse", timeout_pulse, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single byte 0xA5, last=1
    exp_q.push_back(mk(1'b0, 2'b00, 8'hA5));
    drive(1'b0, {9'h000, 9'h1A5}, 1);
    n = 0; gs = 2'b00;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      gs = gs | grant;
    end
    chk("t1_busy_cycles", n, 10 * CPB);
    chk("t1_grant", gs, 2'b00);
    drain();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    // Two 2-byte messages, both held valid
    exp_q.push_back(mk(1'b0, 2'b00, 8'h11));
    exp_q.push_back(mk(1'b0, 2'b01, 8'h12));
    exp_q.push_back(mk(1'b1, 2'b00, 8'h21));
    exp_q.push_back(mk(1'b1, 2'b10, 8'h22));
    fork
      drive(1'b0, {9'h112, 9'h011}, 2);
      drive(1'b1, {9'h122, 9'h021}, 2);
    join
    chk("t2_ready_violations", viol_cnt, 0);

    // Back-to-back single-byte messages alternate owners with one idle cycle
    gap_en = 1;
    exp_q.push_back(mk(1'b0, 2'b00, 8'h40));
    exp_q.push_back(mk(1'b1, 2'b00, 8'h50));
    exp_q.push_back(mk(1'b0, 2'b00, 8'h41));
    exp_q.push_back(mk(1'b1, 2'b00, 8'h51));
    fork
      drive(1'b0, {9'h141, 9'h140}, 2);
      drive(1'b1, {9'h151, 9'h150}, 2);
    join
    drain();
    gap_en = 0;

    // Owner goes silent: timeout releases grant to the waiting requester
    p0 = pulse_cnt;
    exp_q.push_back(mk(1'b0, 2'b00, 8'h33));
    exp_q.push_back(mk(1'b1, 2'b00, 8'h60));
    set_req(1'b0, 1'b1, 8'h33, 1'b0);
    wait_xfer(1'b0);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 8'h00, 1'b0);
    set_req(1'b1, 1'b1, 8'h60, 1'b1);
    n = 0; pg = 2'b00;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (timeout_pulse) break;
      if (!busy) n++;
      pg = grant;
    end
    chk("t4_idle_before_timeout", n, TO);
    chk("t4_grant_before", pg, 2'b01);
    chk("t4_grant_after", grant, 2'b00);
    chk("t4_req1_ready", req1_ready, 1);
    @(posedge clk);
    #1;
    set_req(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t4_pulse_width", timeout_pulse, 0);
    drain();
    chk("t4_pulse_count", pulse_cnt - p0, 1);

    // Owner transfer on the cycle the counter would reach the limit
    p0 = pulse_cnt;
    exp_q.push_back(mk(1'b0, 2'b00, 8'h70));
    exp_q.push_back(mk(1'b0, 2'b01, 8'h71));
    set_req(1'b0, 1'b1, 8'h70, 1'b0);
    wait_xfer(1'b0);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 8'h00, 1'b0);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) n++;
      if (n == TO - 1) break;
    end
    chk("t5_idle_count", n, TO - 1);
    chk("t5_ready_without_valid", req0_ready, 1);
    chk("t5_ready1_blocked", req1_ready, 0);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b1, 8'h71, 1'b1);
    @(negedge clk);
    chk("t5_owner_ready", req0_ready, 1);
    chk("t5_no_pulse", timeout_pulse, 0);
    chk("t5_grant_held", grant, 2'b01);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t5_grant_released", grant, 2'b00);
    chk("t5_no_pulse_after", timeout_pulse, 0);
    drain();
    chk("t5_pulse_count", pulse_cnt - p0, 0);

    // Reset during data bit 3 aborts the frame; next frame is clean
    exp_q.push_back(mk(1'b0, 2'b00, 8'h5A));
    set_req(1'b0, 1'b1, 8'h5A, 1'b0);
    wait_xfer(1'b0);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (4 * CPB + 1) @(posedge clk);
    #1;
    chk("t6_bit3_level", uart_tx, 1);
    chk("t6_grant_locked", grant, 2'b01);
    chk("t6_busy_mid", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_uart_tx", uart_tx, 1);
    chk("t6_grant", grant, 2'b00);
    chk("t6_busy", busy, 0);
    chk("t6_timeout_pulse", timeout_pulse, 0);
    @(posedge clk);
    #1;
    exp_q.push_back(mk(1'b0, 2'b00, 8'hC3));
    drive(1'b0, {9'h000, 9'h1C3}, 1);
    drain();

    chk("ready_violations", viol_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
